md_unit: RTL and testbench
==========================

# md_unit

Multiply/divide unit in the EX stage of the pipelined MIPS core. It executes mult, multu, div, divu, mthi and mtlo, holds the HI/LO register pair, and drives the busy flag consumed by the hazard unit. The hazard unit stalls any decode-stage HI/LO-using instruction while busy is high, so HI/LO reads (mfhi/mflo) always see settled values.

## Interface
- MULT_CYCLES, 5, busy-phase length in cycles for mult/multu; legal 1..255
- DIV_CYCLES, 10, busy-phase length in cycles for div/divu; legal 1..255
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  EX-stage instruction is an MD op this cycle; one-cycle pulse per instruction
- op  in  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7=no-op
- A  in  32  rs operand, already forwarded
- B  in  32  rt operand, already forwarded
- busy  out  1  MD unit occupied; combinational
- hi  out  32  architectural HI register
- lo  out  32  architectural LO register

## Operation
- **State:** 8-bit down-counter `cnt`, 64-bit pending result `{phi, plo}`, pending-valid flag, HI and LO registers.
- **Idle:** `cnt == 0`.
- **mult/multu, start in idle:** at the edge, `{phi, plo}` gets the full 64-bit product. mult is signed, multu is unsigned. `cnt` is loaded with MULT_CYCLES.
- **div/divu, start in idle:** at the edge, `plo` gets the quotient and `phi` gets the remainder. div is signed, divu is unsigned. `cnt` is loaded with DIV_CYCLES.
- **Signed division rules:**
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- **Divide by zero (B==0):** the busy phase still runs for DIV_CYCLES, but HI and LO stay unchanged at completion (pending-valid cleared).
- **Busy phase:** `cnt` decrements each edge. On the edge where `cnt == 1`, HI/LO are loaded from `{phi, plo}` (if pending-valid) and `cnt` becomes 0.
- **mthi/mtlo:** on the start edge, HI (or LO) is loaded with A. No busy phase, and `cnt` is untouched.
- **busy** = (start && op ≤ 3) || (cnt != 0).
- **Start while `cnt != 0`:** ignored entirely, for all ops. Operands are not latched and HI/LO are not written. The hazard unit guarantees this does not occur in legal operation.
- **Start with op 6/7:** no effect.
- **Reset:** when asserted (asynchronous, including mid-operation), cnt=0, pending-valid=0, hi=0, lo=0, and busy=0 once start is low. Any in-flight result is discarded.

## Timing
- Let start for mult/div be high in cycle T.
- busy is high in cycles T .. T+N, where N = MULT_CYCLES or DIV_CYCLES (N+1 cycles total).
- HI/LO show the new values from cycle T+N+1, the same cycle busy first reads 0.
- During T .. T+N, hi/lo hold their previous values.
- mthi/mtlo in cycle T: the new value is visible from T+1; busy stays 0 (absent a running op).
- A start accepted in cycle T+N+1 (back-to-back) is legal and begins a new busy phase.
- Operands A/B are sampled only on the start edge; later changes have no effect.
- Outputs after reset: busy=0, hi=0x00000000, lo=0x00000000.

## Test plan
- **Signed mult:** reset, then mult A=0xFFFFFFFE (−2), B=3 at T → busy high T..T+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA at T+6.
- **multu and mtlo:** multu A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 busy cycles. A following mtlo A=0x1234 → LO=0x1234 next cycle, HI unchanged.
- **Signed div:**
  - div A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF at T+11.
  - divu with the same operands → LO=0x7FFFFFFC, HI=0x00000001.
- **Corner divides:**
  - div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
  - div with B=0 → busy for T..T+10, HI/LO unchanged.
- **Start during busy and reset mid-op:**
  - Start mult while busy from a div → ignored; the div result lands on schedule.
  - Deassert rst_n mid-div → busy=0, hi=lo=0 immediately; no later HI/LO write occurs.

Source files
------------

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : MIPS EX-stage multiply/divide unit with HI/LO pair and busy flag.
// Revision : 1.0
// ============================================================================
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] c_op_mult  = 3'd0;
    localparam logic [2:0] c_op_multu = 3'd1;
    localparam logic [2:0] c_op_div   = 3'd2;
    localparam logic [2:0] c_op_divu  = 3'd3;
    localparam logic [2:0] c_op_mthi  = 3'd4;
    localparam logic [2:0] c_op_mtlo  = 3'd5;

    localparam logic [7:0] c_mult_load = 8'(MULT_CYCLES);
    localparam logic [7:0] c_div_load  = 8'(DIV_CYCLES);

    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] phi_q, phi_d;
    logic [31:0] plo_q, plo_d;
    logic        pend_q, pend_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic               is_signed;
    logic signed [63:0] a_sx, b_sx, prod_s;
    logic [63:0]        prod_u, prod;
    logic               a_neg, b_neg;
    logic [31:0]        a_mag, b_mag, div_b, q_mag, r_mag, quo, rem;

    // op[0] clear selects the signed flavour for both mult and div
    assign is_signed = ~op[0];

    assign a_sx   = 64'($signed(A));
    assign b_sx   = 64'($signed(B));
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign prod   = is_signed ? 64'(prod_s) : prod_u;

    // Divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with rem 0
    assign a_neg = is_signed & A[31];
    assign b_neg = is_signed & B[31];
    assign a_mag = a_neg ? (32'd0 - A) : A;
    assign b_mag = b_neg ? (32'd0 - B) : B;
    assign div_b = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / div_b;
    assign r_mag = a_mag % div_b;
    assign quo   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem   = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        cnt_d  = cnt_q;
        phi_d  = phi_q;
        plo_d  = plo_q;
        pend_d = pend_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
                if (pend_q) begin
                    hi_d = phi_q;
                    lo_d = plo_q;
                end
                pend_d = 1'b0;
            end
        end else if (start) begin
            case (op)
                c_op_mult, c_op_multu: begin
                    {phi_d, plo_d} = prod;
                    pend_d         = 1'b1;
                    cnt_d          = c_mult_load;
                end
                c_op_div, c_op_divu: begin
                    phi_d  = rem;
                    plo_d  = quo;
                    pend_d = (B != 32'd0);
                    cnt_d  = c_div_load;
                end
                c_op_mthi: hi_d = A;
                c_op_mtlo: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 8'd0;
            phi_q  <= 32'd0;
            plo_q  <= 32'd0;
            pend_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            phi_q  <= phi_d;
            plo_q  <= plo_d;
            pend_q <= pend_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign busy = (start && !op[2]) || (cnt_q != 8'd0);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Table-driven self-checking bench for md_unit.
// Revision : 1.0
// ============================================================================
module tb_md_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;
    localparam int NVEC   = 13;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp = 0;
    int n_err = 0;

    md_unit #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .A    (A),
        .B    (B),
        .busy (busy),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic exp_busy,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check({tag, " busy"}, {31'd0, busy}, {31'd0, exp_busy});
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
    endtask

    function automatic int busy_len(input logic [2:0] o);
        if (o <= 3'd1) return MULT_N;
        if (o <= 3'd3) return DIV_N;
        return 0;
    endfunction

    logic [31:0] prev_hi, prev_lo;

    initial begin
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{3'd5, 32'h00001234, 32'h0000BEEF, 32'hFFFFFFFE, 32'h00001234};
        vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC};
        vecs[5]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{3'd2, 32'h12345678, 32'h00000000, 32'h00000000, 32'h80000000};
        vecs[7]  = '{3'd4, 32'hCAFEF00D, 32'h00000000, 32'hCAFEF00D, 32'h80000000};
        vecs[8]  = '{3'd0, 32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD};
        vecs[9]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{3'd6, 32'h55555555, 32'hAAAAAAAA, 32'h00000001, 32'hFFFFFFFD};
        vecs[11] = '{3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[12] = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'd7;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_state("reset", 1'b0, 32'd0, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Each start lands in the cycle right after the previous op settles
        prev_hi = 32'd0;
        prev_lo = 32'd0;
        for (int i = 0; i < NVEC; i++) begin
            start = 1'b1;
            op    = vecs[i].op;
            A     = vecs[i].a;
            B     = vecs[i].b;
            @(negedge clk);
            check_state($sformatf("v%0d start", i), (vecs[i].op <= 3'd3), prev_hi, prev_lo);
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int c = 1; c <= busy_len(vecs[i].op); c++) begin
                A = $urandom;
                B = $urandom;
                @(negedge clk);
                check_state($sformatf("v%0d c%0d", i, c), 1'b1, prev_hi, prev_lo);
                @(posedge clk);
                #1;
            end
            prev_hi = vecs[i].exp_hi;
            prev_lo = vecs[i].exp_lo;
        end
        @(negedge clk);
        check_state("table end", 1'b0, prev_hi, prev_lo);

        // Starts arriving while a divide runs must be dropped entirely
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 3'd3;
        A     = 32'd100;
        B     = 32'd7;
        @(negedge clk);
        check_state("ign c0", 1'b1, prev_hi, prev_lo);
        for (int c = 1; c <= DIV_N; c++) begin
            @(posedge clk);
            #1;
            start = (c == 3) || (c == 5);
            op    = (c == 5) ? 3'd4 : 3'd0;
            A     = (c == 5) ? 32'h0000DEAD : 32'd3;
            B     = 32'd3;
            @(negedge clk);
            check_state($sformatf("ign c%0d", c), 1'b1, prev_hi, prev_lo);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check_state("ign done", 1'b0, 32'd2, 32'd14);

        // Asynchronous reset mid-divide discards the pending result
        @(posedge clk);
        #1;
        start = 1'b1;
        op    = 3'd2;
        A     = 32'd100;
        B     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("rst mid", 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < DIV_N + 4; c++) begin
            @(negedge clk);
            check_state($sformatf("post rst c%0d", c), 1'b0, 32'd0, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
